// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: datapath widths,
// ALU opcodes and the forwarding-source encoding.
package mips_pkg;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADDU = 4'b0010,
    ALU_SRL  = 4'b0011,
    ALU_SUBU = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_XOR  = 4'b1001,
    ALU_SLL  = 4'b1010,
    ALU_SRA  = 4'b1011,
    ALU_NOR  = 4'b1100,
    ALU_SLTU = 4'b1110
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_NONE,
    FWD_EXMEM,
    FWD_MEMWB
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Priority forwarding select for one source operand: the younger EX/MEM
// result beats MEM/WB, and register 0 is never forwarded.
module fwd_mux
  import mips_pkg::*;
#(
  parameter int XLEN = mips_pkg::XLEN,
  parameter int RW   = mips_pkg::RW
) (
  input  logic [RW-1:0]   src,
  input  logic [XLEN-1:0] reg_data,
  input  logic            exmem_reg_write,
  input  logic [RW-1:0]   exmem_wb_reg,
  input  logic [XLEN-1:0] exmem_alu_out,
  input  logic            memwb_reg_write,
  input  logic [RW-1:0]   memwb_wb_reg,
  input  logic [XLEN-1:0] memwb_data,
  output logic [XLEN-1:0] data
);

  fwd_sel_e sel;
  logic     src_nz;

  assign src_nz = (src != '0);

  always_comb begin
    sel = FWD_NONE;
    if (exmem_reg_write && exmem_wb_reg == src && src_nz)
      sel = FWD_EXMEM;
    else if (memwb_reg_write && memwb_wb_reg == src && src_nz)
      sel = FWD_MEMWB;
  end

  always_comb begin
    data = reg_data;
    case (sel)
      FWD_EXMEM: data = exmem_alu_out;
      FWD_MEMWB: data = memwb_data;
      default:   data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side forwarding, ALU operand selection
// and load-use hazard detection.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int XLEN = mips_pkg::XLEN,
  parameter int RW   = mips_pkg::RW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_rs_data,
  input  logic [XLEN-1:0] id_rt_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_shamt,
  input  logic [RW-1:0]   id_rs,
  input  logic [RW-1:0]   id_rt,
  input  logic [RW-1:0]   id_wb_reg,
  input  logic [3:0]      id_alu_control,
  input  logic            id_alu_src,
  input  logic            id_shift_src,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            exmem_reg_write,
  input  logic [RW-1:0]   exmem_wb_reg,
  input  logic [XLEN-1:0] exmem_alu_out,
  input  logic            memwb_reg_write,
  input  logic [RW-1:0]   memwb_wb_reg,
  input  logic [XLEN-1:0] memwb_data,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] ex_store_data,
  output logic            ex_valid,
  output logic [RW-1:0]   ex_wb_reg,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            load_use_hazard
);

  logic            valid_q;
  logic [XLEN-1:0] rs_data_q, rt_data_q, imm_q;
  logic [4:0]      shamt_q;
  logic [RW-1:0]   rs_q, rt_q, wb_reg_q;
  logic [3:0]      alu_control_q;
  logic            alu_src_q, shift_src_q;
  logic            reg_write_q, mem_read_q, mem_write_q;

  logic [XLEN-1:0] fwd_rs, fwd_rt;

  // A flush is a bubble: identical to reset, and it overrides a stall.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      valid_q       <= 1'b0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      imm_q         <= '0;
      shamt_q       <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      wb_reg_q      <= '0;
      alu_control_q <= '0;
      alu_src_q     <= 1'b0;
      shift_src_q   <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else if (!stall_i) begin
      valid_q       <= id_valid;
      rs_data_q     <= id_rs_data;
      rt_data_q     <= id_rt_data;
      imm_q         <= id_imm;
      shamt_q       <= id_shamt;
      rs_q          <= id_rs;
      rt_q          <= id_rt;
      wb_reg_q      <= id_wb_reg;
      alu_control_q <= id_alu_control;
      alu_src_q     <= id_alu_src;
      shift_src_q   <= id_shift_src;
      reg_write_q   <= id_valid & id_reg_write;
      mem_read_q    <= id_valid & id_mem_read;
      mem_write_q   <= id_valid & id_mem_write;
    end
  end

  fwd_mux #(.XLEN(XLEN), .RW(RW)) u_fwd_rs (
    .src             (rs_q),
    .reg_data        (rs_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_wb_reg    (exmem_wb_reg),
    .exmem_alu_out   (exmem_alu_out),
    .memwb_reg_write (memwb_reg_write),
    .memwb_wb_reg    (memwb_wb_reg),
    .memwb_data      (memwb_data),
    .data            (fwd_rs)
  );

  fwd_mux #(.XLEN(XLEN), .RW(RW)) u_fwd_rt (
    .src             (rt_q),
    .reg_data        (rt_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_wb_reg    (exmem_wb_reg),
    .exmem_alu_out   (exmem_alu_out),
    .memwb_reg_write (memwb_reg_write),
    .memwb_wb_reg    (memwb_wb_reg),
    .memwb_data      (memwb_data),
    .data            (fwd_rt)
  );

  assign alu_in1       = shift_src_q ? {{(XLEN-5){1'b0}}, shamt_q} : fwd_rs;
  assign alu_in2       = alu_src_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_control   = valid_q ? alu_control_q : 4'b0000;

  assign ex_valid     = valid_q;
  assign ex_wb_reg    = wb_reg_q;
  assign ex_reg_write = valid_q & reg_write_q;
  assign ex_mem_read  = valid_q & mem_read_q;
  assign ex_mem_write = valid_q & mem_write_q;

  // rt is compared even for immediate forms; a spurious stall is harmless.
  assign load_use_hazard = valid_q & mem_read_q & (wb_reg_q != '0) & id_valid &
                           ((wb_reg_q == id_rs) | (wb_reg_q == id_rt));

endmodule
